// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps stim through every code, captures two responses into truth tables and compares them
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 resp_a,
  input  logic                 resp_b,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_a,
  output logic [2**N_IN-1:0]   table_b,
  output logic [N_IN:0]        mismatch_count,
  output logic                 first_valid,
  output logic [N_IN-1:0]      first_idx,
  output logic                 equal
);
  localparam logic [N_IN-1:0] LastIdx = N_IN'(2**N_IN - 1);
  localparam logic [3:0]      CntEnd  = 4'(SETTLE - 1);
  typedef enum logic [1:0] {StIdle, StWait, StCapture, StDone} state_t;
  state_t state;
  logic [N_IN-1:0] idx;
  logic [3:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= StIdle;
      idx            <= '0;
      cnt            <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_a        <= '0;
      table_b        <= '0;
      mismatch_count <= '0;
      first_valid    <= 1'b0;
      first_idx      <= '0;
      equal          <= 1'b0;
    end else begin
      case (state)
        StIdle: if (start) begin
          table_a        <= '0;
          table_b        <= '0;
          mismatch_count <= '0;
          first_valid    <= 1'b0;
          first_idx      <= '0;
          equal          <= 1'b0;
          idx            <= '0;
          stim           <= '0;
          cnt            <= '0;
          busy           <= 1'b1;
          state          <= StWait;
        end
        StWait: begin
          cnt <= cnt + 1'b1;
          if (cnt == CntEnd) state <= StCapture;
        end
        StCapture: begin
          table_a[idx] <= resp_a;
          table_b[idx] <= resp_b;
          if (resp_a != resp_b) begin
            mismatch_count <= mismatch_count + 1'b1;
            if (!first_valid) begin
              first_valid <= 1'b1;
              first_idx   <= idx;
            end
          end
          // terminal check precedes the increment, so idx never wraps
          if (idx == LastIdx) begin
            stim  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end else begin
            idx   <= idx + 1'b1;
            stim  <= idx + 1'b1;
            cnt   <= '0;
            state <= StWait;
          end
        end
        StDone: begin
          done  <= 1'b0;
          equal <= (mismatch_count == '0);
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: two instances (SETTLE 1 and 3) checked against a timing and truth-table model
module tb_truth_table_sweeper;
  typedef struct packed {
    logic [7:0] ta;
    logic [7:0] tb;
    logic [3:0] mc;
    logic       fv;
    logic [2:0] fi;
    logic       eq;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, start;
  logic [7:0] tabA, tabB;
  logic [2:0] stimV [2];
  logic       busyV [2], doneV [2], fvV [2], eqV [2], ra [2], rb [2];
  logic [7:0] tabAV [2], tabBV [2];
  logic [3:0] mcV [2];
  logic [2:0] fiV [2];
  int vectors = 0, fails = 0;
  int act [2] = '{0, 0};
  int e [2]   = '{0, 0};
  int clr [2] = '{0, 0};
  int len [2] = '{16, 32};
  int per [2] = '{2, 4};
  exp_t q0 [$];
  exp_t q1 [$];
  always #5 clk = ~clk;
  assign ra[0] = tabA[stimV[0]];
  assign rb[0] = tabB[stimV[0]];
  assign ra[1] = tabA[stimV[1]];
  assign rb[1] = tabB[stimV[1]];
  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stimV[0]), .resp_a(ra[0]), .resp_b(rb[0]),
    .busy(busyV[0]), .done(doneV[0]), .table_a(tabAV[0]), .table_b(tabBV[0]),
    .mismatch_count(mcV[0]), .first_valid(fvV[0]), .first_idx(fiV[0]), .equal(eqV[0]));
  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stimV[1]), .resp_a(ra[1]), .resp_b(rb[1]),
    .busy(busyV[1]), .done(doneV[1]), .table_a(tabAV[1]), .table_b(tabBV[1]),
    .mismatch_count(mcV[1]), .first_valid(fvV[1]), .first_idx(fiV[1]), .equal(eqV[1]));
  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", nm, i, $time, got, want);
    end
  endtask
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    r = '0;
    r.ta = a;
    r.tb = b;
    for (int k = 0; k < 8; k++)
      if (a[k] != b[k]) begin
        if (!r.fv) begin
          r.fv = 1'b1;
          r.fi = 3'(k);
        end
        r.mc = r.mc + 4'd1;
      end
    r.eq = (r.mc == 4'd0);
    return r;
  endfunction
  function automatic logic [7:0] sopTab();
    logic [7:0] t;
    logic [2:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      t[k] = (!v[2] & !v[1]) | (!v[1] & v[0]) | (v[1] & !v[0]);
    end
    return t;
  endfunction
  function automatic logic [7:0] posTab();
    logic [7:0] t;
    logic [2:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      t[k] = (!v[2] | v[1] | v[0]) & (!v[1] | !v[0]);
    end
    return t;
  endfunction
  always @(negedge clk) begin
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      if (act[i] != 0) begin
        chk("stim", i, stimV[i], e[i] < len[i] ? e[i] / per[i] : 0);
        chk("busy", i, busyV[i], e[i] < len[i]);
        chk("done", i, doneV[i], e[i] == len[i]);
        if (e[i] == 0) begin
          chk("clear_tables", i, {tabAV[i], tabBV[i]}, 0);
          chk("clear_flags", i, {mcV[i], fvV[i], eqV[i]}, 0);
        end
        if (e[i] == len[i] + 1) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) chk("queue_empty", i, 1, 0);
          else begin
            x = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("table_a", i, tabAV[i], x.ta);
            chk("table_b", i, tabBV[i], x.tb);
            chk("mismatch_count", i, mcV[i], x.mc);
            chk("first_valid", i, fvV[i], x.fv);
            if (x.fv) chk("first_idx", i, fiV[i], x.fi);
            chk("equal", i, eqV[i], x.eq);
          end
        end
      end else begin
        chk("idle_busy", i, busyV[i], 0);
        chk("idle_done", i, doneV[i], 0);
        chk("idle_stim", i, stimV[i], 0);
        if (clr[i] != 0) begin
          chk("reset_tables", i, {tabAV[i], tabBV[i]}, 0);
          chk("reset_flags", i, {mcV[i], fvV[i], fiV[i], eqV[i]}, 0);
          clr[i] = 0;
        end
      end
      if (!rst_n) begin
        act[i] = 0;
        clr[i] = 1;
        if (i == 0) q0.delete(); else q1.delete();
      end else begin
        if (act[i] != 0 && e[i] == len[i] + 1) act[i] = 0;
        if (act[i] != 0) e[i]++;
        else if (start) begin
          act[i] = 1;
          e[i] = 0;
          if (i == 0) q0.push_back(model(tabA, tabB)); else q1.push_back(model(tabA, tabB));
        end
      end
    end
  end
  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic waitIdle();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      if (act[0] == 0 && act[1] == 0) return;
    end
    chk("idle_timeout", 0, 1, 0);
  endtask
  task automatic sweep();
    pulseStart();
    waitIdle();
    @(posedge clk); #1;
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    tabA = sopTab();
    tabB = posTab();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sweep();
    chk("sop_table_const", 0, tabAV[0], 8'h67);
    chk("pos_table_const", 0, tabBV[0], 8'h67);
    chk("equal_const", 0, eqV[0], 1);
    tabB = sopTab() ^ 8'h20;
    sweep();
    chk("xor5_table_const", 0, tabBV[0], 8'h47);
    chk("xor5_first_idx_const", 0, fiV[0], 5);
    tabB = 8'h00;
    sweep();
    chk("zero_count_const", 0, mcV[0], 5);
    tabB = posTab();
    sweep();
    chk("recover_count_const", 0, mcV[0], 0);
    pulseStart();
    begin
      int n;
      for (n = 0; n < 100 && !(busyV[0] && stimV[0] == 3); n++) @(posedge clk);
      if (n == 100) chk("stim3_timeout", 0, 1, 0);
    end
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    sweep();
    pulseStart();
    repeat (5) @(posedge clk);
    pulseStart();
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    repeat (40) @(posedge clk);
    #1 start = 1'b0;
    waitIdle();
    for (int r = 0; r < 6; r++) begin
      tabA = 8'($urandom);
      tabB = ($urandom_range(0, 2) == 0) ? tabA : tabA ^ 8'($urandom);
      sweep();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential stimulus and response collector for small combinational logic blocks. It steps an N_IN-bit input vector through all 2^N_IN codes and captures two candidate implementations of the same function (for example a sum-of-products form and a product-of-sums form) into truth-table registers. It compares the two responses at every code and reports the results. It sits in front of the gate-level minterm/maxterm blocks as their on-chip driver and checker.

Parameters:
N_IN, 4, number of function inputs; legal range 1..6.
SETTLE, 1, wait cycles after each stim change before capture; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  begins a sweep; sampled only in IDLE.
stim  output  N_IN  input vector driven to both blocks under test; stim[N_IN-1] is the MSB (input a).
resp_a  input  1  response of implementation A.
resp_b  input  1  response of implementation B.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when the sweep completes.
table_a  output  2^N_IN  captured truth table of A; bit k holds the response at stim==k.
table_b  output  2^N_IN  captured truth table of B; same indexing as table_a.
mismatch_count  output  N_IN+1  number of codes where resp_a != resp_b.
first_valid  output  1  at least one mismatch has been recorded.
first_idx  output  N_IN  lowest code that mismatched; valid only when first_valid is high.
equal  output  1  high when mismatch_count == 0 and the last sweep has completed.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low. When rst_n is sampled low:
  - all outputs and internal registers go to 0, including equal;
  - the state goes to IDLE.
  - This applies mid-sweep: the partial sweep is discarded, and no done pulse is generated.
- IDLE state:
  - stim = 0, busy = 0.
  - Results from the last completed sweep are held.
  - If start = 1 is sampled: clear table_a, table_b, mismatch_count, first_valid, first_idx and equal; set idx = 0, stim = 0, cnt = 0; go to WAIT.
- WAIT state:
  - busy = 1, stim = idx.
  - cnt increments every cycle.
  - When cnt == SETTLE-1, go to CAPTURE on the next edge.
- CAPTURE state (one cycle):
  - On its edge, write table_a[idx] <= resp_a and table_b[idx] <= resp_b.
  - If resp_a != resp_b: mismatch_count increments. If first_valid is still 0, set first_valid <= 1 and first_idx <= idx.
  - If idx == 2^N_IN-1: set stim <= 0 and go to DONE.
  - Otherwise: idx <= idx+1, stim <= idx+1, cnt <= 0, and go to WAIT.
- DONE state (one cycle):
  - done = 1, busy = 0.
  - equal <= (mismatch_count == 0).
  - Go to IDLE unconditionally.
- Timing:
  - Each code occupies SETTLE+1 cycles.
  - Taking the edge that samples start as edge 0, the capture for code k happens at edge (k+1)(SETTLE+1).
  - done is high for exactly the cycle after edge 2^N_IN·(SETTLE+1).
- start handling:
  - start is ignored in WAIT, CAPTURE and DONE; there is no restart or abort.
  - If start is held high continuously, a new sweep begins on the first IDLE cycle after DONE.
- Widths:
  - mismatch_count saturates naturally at 2^N_IN, which fits in N_IN+1 bits.
  - idx wraps are never reached, because the terminal compare happens before any increment.
- Response sampling: resp_a and resp_b are sampled only in CAPTURE. Their values in all other states are don't-care.
- Stability: table and flag outputs do not change between done and the next accepted start.

Test Plan:
1. N_IN=3, SETTLE=1. resp_a = !a!b + !bc + b!c and resp_b = (!a+b+c)(!b+!c), with a=stim[2]. Pulse start. Required:
   - done pulses the cycle after edge 16; busy is high for the 16 cycles before it;
   - table_a = table_b = 8'h67;
   - mismatch_count = 0, first_valid = 0, equal = 1.
2. Same setup, but resp_b = resp_a XOR (stim==5). Required:
   - table_b = 8'h47;
   - mismatch_count = 1, first_valid = 1, first_idx = 5, equal = 0.
3. Same setup, resp_b tied to 0. Required: table_b = 8'h00, mismatch_count = 5, first_idx = 0. Then run a second sweep with the correct resp_b: all results clear at start and end at the values of scenario 1.
4. N_IN=3, SETTLE=3. Required: each stim value is held 4 cycles (0,0,0,0,1,1,1,1,...), and done is high the cycle after edge 32.
5. Drive rst_n low for one cycle while stim==3 in WAIT. Required:
   - next cycle: state IDLE, stim = 0, busy = 0, tables = 0, no done pulse;
   - a subsequent start completes normally.
6. Re-pulse start mid-sweep: no effect on stim sequence or timing. Hold start high through DONE: a new sweep begins the following cycle, with busy high again.
